counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Command-driven controller for the prescaled 24-bit counter datapath in the board test designs. It sequences start/stop/resume/clear of the counter and owns the prescaler, which has a programmable limit. It detects a programmable terminal count and supports one-shot or auto-reload operation. The block sits between the `io_in` control pins or a host command source and the counter value driven onto `io_out`.

## Interface
- `CTR_W`, 24, counter width
- `PRE_W`, 16, prescaler width
- `PRESCALE_RESET`, 1000, prescale limit after reset
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command strobe; accepted when `cmd_valid && cmd_ready`
- `cmd_op`  in  2  00 START, 01 STOP, 10 LOAD, 11 CLEAR
- `cmd_data`  in  CTR_W  terminal count for LOAD; ignored otherwise
- `pre_limit`  in  PRE_W  prescale limit, sampled on START from IDLE/DONE
- `auto_reload`  in  1  mode, sampled on START from IDLE/DONE
- `cmd_ready`  out  1  command can be accepted this cycle
- `ctr`  out  CTR_W  counter value (registered)
- `tick`  out  1  one-cycle pulse on each counter update
- `done`  out  1  one-cycle pulse on terminal event
- `busy`  out  1  high in RUN
- `state`  out  2  IDLE 00, RUN 01, HOLD 10, DONE 11

## Operation
- Reset values: state IDLE, `ctr`=0, prescaler=0, terminal register all ones, limit register=`PRESCALE_RESET`, mode=one-shot, `tick`=0, `done`=0, `busy`=0, `cmd_ready`=1.
- Prescaler counts only in RUN, from 0 to the limit register. On the edge where prescaler==limit, the prescaler goes to 0 and a counter update occurs. Limit 0 gives an update every cycle.
- Counter update when `ctr` >= terminal register (terminal event):
  - Auto-reload: `ctr`<=0, `done` pulse, state stays RUN.
  - One-shot: `ctr` holds its value, `done` pulse, state goes to DONE.
- Counter update otherwise: `ctr`<=`ctr`+1, modulo 2^CTR_W.
- START:
  - From IDLE or DONE: clears `ctr` and prescaler, samples `pre_limit` and `auto_reload`, goes to RUN.
  - From HOLD: resumes in RUN with `ctr`, prescaler and mode unchanged.
  - In RUN: accepted, no effect.
- STOP: RUN goes to HOLD with counter and prescaler frozen. No effect in other states.
- LOAD: writes `cmd_data` to the terminal register in any state with no state change. A terminal value below the current `ctr` triggers a terminal event at the next update.
- CLEAR: any state goes to IDLE with `ctr`=0 and prescaler=0. Terminal, limit and mode registers are kept.
- Command and update on the same edge:
  - STOP or CLEAR win; no update, no `tick`, no `done`.
  - LOAD and START-in-RUN let the update proceed. The terminal compare uses the terminal register value from before the LOAD.
- `rst` overrides everything, including mid-count.

## Timing
- Command handshake:
  - `cmd_ready` drops for exactly one cycle after each accepted command, so back-to-back commands are accepted at most every 2 cycles.
  - The state change is visible on `state`, `busy` and `ctr` in the cycle after acceptance.
- Update outputs:
  - `tick` and `done` are registered and assert in the same cycle the new `ctr` value appears.
  - After START with limit L, the first `tick` occurs L+1 cycles after the START acceptance cycle.
- Full period from START: (T+1)·(L+1) cycles until `done`, where T is the terminal count.

## Configuration
- `COUNTER_SEQUENCER_CAPTURE_EN` defined:
  - Adds input `capture` (1 bit) and output `cap_value` (CTR_W bits), reset value 0.
  - A `capture` pulse latches the current `ctr` into `cap_value` on that edge, in any state.
  - If `capture` coincides with an update, `cap_value` gets the pre-update value.
- Macro undefined: both ports and the register are absent, and all other behaviour is identical.

## Test plan
- Reset, then LOAD 4, then START with `pre_limit`=3 and `auto_reload`=0:
  - `tick` every 4 cycles; `ctr` steps 1,2,3,4.
  - `done` and state DONE 20 cycles after START acceptance; `ctr` holds 4.
- Same setup with `auto_reload`=1:
  - `ctr` goes 4→0 with a `done` pulse every 20 cycles.
  - `busy` stays 1 throughout.
- START, STOP at `ctr`=2 mid-prescale, wait 50 cycles, then START:
  - `ctr` stays 2 in HOLD.
  - Count resumes with the same prescaler phase and no reset of `ctr`.
- `pre_limit`=0, terminal 2^24−1, STOP after 10 cycles: `ctr`=10. Separately, LOAD 3 while `ctr`=7 in RUN: `done` at the next update.
- CLEAR issued on the same edge as a terminal update: state IDLE, `ctr`=0, no `done`, no `tick`. Also check that `cmd_ready` is low for one cycle after each command.
- With the macro defined, `capture` at `ctr`=5 on an update edge: `cap_value`=5 and `ctr`=6.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven start/stop/resume/clear sequencer for a prescaled counter.
// Optional capture register is enabled by defining COUNTER_SEQUENCER_CAPTURE_EN.
//
// state | meaning
// IDLE  | stopped, counter and prescaler cleared
// RUN   | prescaler running, counter advances on each prescale wrap
// HOLD  | paused, counter and prescaler frozen until START
// DONE  | one-shot terminal reached, counter holds final value
module counter_sequencer #(
  parameter int          CTR_W          = 24,
  parameter int          PRE_W          = 16,
  parameter int unsigned PRESCALE_RESET = 1000
) (
  input  logic             clk,
  input  logic             rst,
`ifdef COUNTER_SEQUENCER_CAPTURE_EN
  input  logic             capture,
  output logic [CTR_W-1:0] cap_value,
`endif
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [CTR_W-1:0] cmd_data,
  input  logic [PRE_W-1:0] pre_limit,
  input  logic             auto_reload,
  output logic             cmd_ready,
  output logic [CTR_W-1:0] ctr,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CTR_W-1:0] term_q, term_d;
  logic [PRE_W-1:0] limit_q, limit_d;
  logic             auto_q, auto_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             cmd_acc;
  logic             pre_hit;

  assign cmd_acc = cmd_valid && ready_q;
  assign pre_hit = (pre_q == limit_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      pre_q   <= '0;
      term_q  <= '1;
      limit_q <= PRE_W'(PRESCALE_RESET);
      auto_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      pre_q   <= pre_d;
      term_q  <= term_d;
      limit_q <= limit_d;
      auto_q  <= auto_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    pre_d   = pre_q;
    term_d  = term_q;
    limit_d = limit_q;
    auto_d  = auto_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = ~cmd_acc;

    // Counting first; a coincident command below may then override it.
    if (state_q == S_RUN) begin
      if (pre_hit) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (ctr_q >= term_q) begin
          done_d = 1'b1;
          if (auto_q) ctr_d = '0;
          else        state_d = S_DONE;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    if (cmd_acc) begin
      case (cmd_op)
        OP_START: begin
          if (state_q == S_IDLE || state_q == S_DONE) begin
            state_d = S_RUN;
            ctr_d   = '0;
            pre_d   = '0;
            limit_d = pre_limit;
            auto_d  = auto_reload;
          end else if (state_q == S_HOLD) begin
            state_d = S_RUN;
          end
        end
        OP_STOP: begin
          if (state_q == S_RUN) begin
            state_d = S_HOLD;
            ctr_d   = ctr_q;
            pre_d   = pre_q;
            tick_d  = 1'b0;
            done_d  = 1'b0;
          end
        end
        OP_LOAD: term_d = cmd_data;
        OP_CLEAR: begin
          state_d = S_IDLE;
          ctr_d   = '0;
          pre_d   = '0;
          tick_d  = 1'b0;
          done_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready = ready_q;
    ctr       = ctr_q;
    tick      = tick_q;
    done      = done_q;
    busy      = (state_q == S_RUN);
    state     = state_q;
  end

`ifdef COUNTER_SEQUENCER_CAPTURE_EN
  logic [CTR_W-1:0] cap_value_q, cap_value_d;

  // Captures the value held before this edge, so a coincident update is not seen.
  always_comb cap_value_d = capture ? ctr_q : cap_value_q;

  always_ff @(posedge clk) begin
    if (rst) cap_value_q <= '0;
    else     cap_value_q <= cap_value_d;
  end

  always_comb cap_value = cap_value_q;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the command/prescale/count rules.
module tb_counter_sequencer;
  localparam int CTR_W = 24;
  localparam int PRE_W = 16;
  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;
  localparam int unsigned MAXC    = 32'h00FF_FFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CTR_W-1:0] cmd_data;
  logic [PRE_W-1:0] pre_limit;
  logic             auto_reload;
  logic             cmd_ready;
  logic [CTR_W-1:0] ctr;
  logic             tick;
  logic             done;
  logic             busy;
  logic [1:0]       state;
`ifdef COUNTER_SEQUENCER_CAPTURE_EN
  logic             capture;
  logic [CTR_W-1:0] cap_value;
`endif

  int checks = 0;
  int failures = 0;

  counter_sequencer dut (
    .clk(clk),
    .rst(rst),
`ifdef COUNTER_SEQUENCER_CAPTURE_EN
    .capture(capture),
    .cap_value(cap_value),
`endif
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .pre_limit(pre_limit),
    .auto_reload(auto_reload),
    .cmd_ready(cmd_ready),
    .ctr(ctr),
    .tick(tick),
    .done(done),
    .busy(busy),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog sim_time_expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0;
    cmd_op    = OP_START;
    cmd_data  = '0;
`ifdef COUNTER_SEQUENCER_CAPTURE_EN
    capture   = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Waits (bounded) for cmd_ready, then presents one command for exactly one edge.
  task automatic send(input logic [1:0] op, input logic [CTR_W-1:0] data);
    int n;
    n = 0;
    while (!cmd_ready && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_wait got=%0b want=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    pre_limit = '0;
    auto_reload = 1'b0;
    rst = 1'b1;
    step();
    step();
    checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", state, ST_IDLE); end
    checks++; if (ctr !== 24'd0) begin failures++; $display("FAIL reset_ctr got=%0d want=0", ctr); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%0b want=0", tick); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b want=1", cmd_ready); end
`ifdef COUNTER_SEQUENCER_CAPTURE_EN
    checks++; if (cap_value !== 24'd0) begin failures++; $display("FAIL reset_cap got=%0d want=0", cap_value); end
`endif
    rst = 1'b0;
    step();
    checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL reset_idle_after got=%0d want=%0d", state, ST_IDLE); end
  endtask

  task automatic test_oneshot();
    int e_ctr;
    logic e_tick, e_done;
    logic [1:0] e_state;
    do_reset();
    send(OP_LOAD, 24'd4);
    pre_limit = 16'd3;
    auto_reload = 1'b0;
    send(OP_START, 24'd0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL oneshot_busy_start got=%0b want=1", busy); end
    for (int k = 1; k <= 26; k++) begin
      step();
      e_ctr   = (k >= 16) ? 4 : k / 4;
      e_tick  = (k % 4 == 0) && (k <= 20);
      e_done  = (k == 20);
      e_state = (k >= 20) ? ST_DONE : ST_RUN;
      checks++; if (ctr !== e_ctr) begin failures++; $display("FAIL oneshot_ctr k=%0d got=%0d want=%0d", k, ctr, e_ctr); end
      checks++; if (tick !== e_tick) begin failures++; $display("FAIL oneshot_tick k=%0d got=%0b want=%0b", k, tick, e_tick); end
      checks++; if (done !== e_done) begin failures++; $display("FAIL oneshot_done k=%0d got=%0b want=%0b", k, done, e_done); end
      checks++; if (state !== e_state) begin failures++; $display("FAIL oneshot_state k=%0d got=%0d want=%0d", k, state, e_state); end
    end
  endtask

  task automatic test_auto_reload();
    int e_ctr;
    logic e_tick, e_done;
    do_reset();
    send(OP_LOAD, 24'd4);
    pre_limit = 16'd3;
    auto_reload = 1'b1;
    send(OP_START, 24'd0);
    for (int k = 1; k <= 60; k++) begin
      step();
      e_ctr  = (k / 4) % 5;
      e_tick = (k % 4 == 0);
      e_done = (k % 20 == 0);
      checks++; if (ctr !== e_ctr) begin failures++; $display("FAIL auto_ctr k=%0d got=%0d want=%0d", k, ctr, e_ctr); end
      checks++; if (tick !== e_tick) begin failures++; $display("FAIL auto_tick k=%0d got=%0b want=%0b", k, tick, e_tick); end
      checks++; if (done !== e_done) begin failures++; $display("FAIL auto_done k=%0d got=%0b want=%0b", k, done, e_done); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL auto_busy k=%0d got=%0b want=1", k, busy); end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL midcount_reset_state got=%0d want=%0d", state, ST_IDLE); end
    checks++; if (ctr !== 24'd0) begin failures++; $display("FAIL midcount_reset_ctr got=%0d want=0", ctr); end
  endtask

  task automatic test_hold_resume();
    int e_ctr;
    logic e_tick;
    do_reset();
    send(OP_LOAD, 24'd100);
    pre_limit = 16'd3;
    auto_reload = 1'b0;
    send(OP_START, 24'd0);
    for (int k = 1; k <= 9; k++) step();
    checks++; if (ctr !== 24'd2) begin failures++; $display("FAIL hold_pre_ctr got=%0d want=2", ctr); end
    send(OP_STOP, 24'd0);
    checks++; if (state !== ST_HOLD) begin failures++; $display("FAIL hold_state got=%0d want=%0d", state, ST_HOLD); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy got=%0b want=0", busy); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL hold_ready_low got=%0b want=0", cmd_ready); end
    for (int k = 1; k <= 50; k++) begin
      step();
      checks++; if (ctr !== 24'd2) begin failures++; $display("FAIL hold_ctr k=%0d got=%0d want=2", k, ctr); end
      checks++; if (tick !== 1'b0) begin failures++; $display("FAIL hold_tick k=%0d got=%0b want=0", k, tick); end
    end
    // A different limit on the pins must not affect a resume.
    pre_limit = 16'd0;
    send(OP_START, 24'd0);
    checks++; if (state !== ST_RUN) begin failures++; $display("FAIL resume_state got=%0d want=%0d", state, ST_RUN); end
    checks++; if (ctr !== 24'd2) begin failures++; $display("FAIL resume_ctr0 got=%0d want=2", ctr); end
    for (int j = 1; j <= 7; j++) begin
      step();
      e_tick = (j == 3) || (j == 7);
      e_ctr  = (j < 3) ? 2 : ((j < 7) ? 3 : 4);
      checks++; if (ctr !== e_ctr) begin failures++; $display("FAIL resume_ctr j=%0d got=%0d want=%0d", j, ctr, e_ctr); end
      checks++; if (tick !== e_tick) begin failures++; $display("FAIL resume_tick j=%0d got=%0b want=%0b", j, tick, e_tick); end
    end
  endtask

  task automatic test_limit_zero();
    do_reset();
    pre_limit = 16'd0;
    auto_reload = 1'b0;
    send(OP_START, 24'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (ctr !== k) begin failures++; $display("FAIL lim0_ctr k=%0d got=%0d want=%0d", k, ctr, k); end
      checks++; if (tick !== 1'b1) begin failures++; $display("FAIL lim0_tick k=%0d got=%0b want=1", k, tick); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL lim0_done k=%0d got=%0b want=0", k, done); end
    end
    send(OP_STOP, 24'd0);
    checks++; if (ctr !== 24'd10) begin failures++; $display("FAIL lim0_stop_ctr got=%0d want=10", ctr); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL lim0_stop_tick got=%0b want=0", tick); end
    checks++; if (state !== ST_HOLD) begin failures++; $display("FAIL lim0_stop_state got=%0d want=%0d", state, ST_HOLD); end
  endtask

  task automatic test_load_below();
    do_reset();
    pre_limit = 16'd3;
    auto_reload = 1'b0;
    send(OP_START, 24'd0);
    for (int k = 1; k <= 28; k++) step();
    checks++; if (ctr !== 24'd7) begin failures++; $display("FAIL loadlow_pre_ctr got=%0d want=7", ctr); end
    send(OP_LOAD, 24'd3);
    step();
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL loadlow_early_done got=%0b want=0", done); end
    checks++; if (state !== ST_RUN) begin failures++; $display("FAIL loadlow_early_state got=%0d want=%0d", state, ST_RUN); end
    step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL loadlow_done got=%0b want=1", done); end
    checks++; if (ctr !== 24'd7) begin failures++; $display("FAIL loadlow_ctr got=%0d want=7", ctr); end
    checks++; if (state !== ST_DONE) begin failures++; $display("FAIL loadlow_state got=%0d want=%0d", state, ST_DONE); end

    // LOAD on an update edge: that update still compares against the old terminal.
    do_reset();
    pre_limit = 16'd0;
    send(OP_START, 24'd0);
    for (int k = 1; k <= 7; k++) step();
    send(OP_LOAD, 24'd3);
    checks++; if (ctr !== 24'd8) begin failures++; $display("FAIL loadedge_ctr got=%0d want=8", ctr); end
    checks++; if (tick !== 1'b1) begin failures++; $display("FAIL loadedge_tick got=%0b want=1", tick); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL loadedge_done got=%0b want=0", done); end
    step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL loadedge_next_done got=%0b want=1", done); end
    checks++; if (ctr !== 24'd8) begin failures++; $display("FAIL loadedge_next_ctr got=%0d want=8", ctr); end
    checks++; if (state !== ST_DONE) begin failures++; $display("FAIL loadedge_next_state got=%0d want=%0d", state, ST_DONE); end
  endtask

  task automatic test_clear_on_terminal();
    do_reset();
    send(OP_LOAD, 24'd2);
    pre_limit = 16'd1;
    auto_reload = 1'b0;
    send(OP_START, 24'd0);
    for (int k = 1; k <= 5; k++) step();
    checks++; if (ctr !== 24'd2) begin failures++; $display("FAIL clr_pre_ctr got=%0d want=2", ctr); end
    send(OP_CLEAR, 24'd0);
    checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL clr_state got=%0d want=%0d", state, ST_IDLE); end
    checks++; if (ctr !== 24'd0) begin failures++; $display("FAIL clr_ctr got=%0d want=0", ctr); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL clr_done got=%0b want=0", done); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL clr_tick got=%0b want=0", tick); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL clr_ready_low got=%0b want=0", cmd_ready); end
    step();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL clr_ready_back got=%0b want=1", cmd_ready); end
    checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL clr_state_stay got=%0d want=%0d", state, ST_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic e_ready;
    do_reset();
    cmd_valid = 1'b1;
    cmd_op = OP_LOAD;
    for (int k = 1; k <= 8; k++) begin
      cmd_data = 24'($urandom_range(0, 255));
      step();
      e_ready = (k % 2 == 0);
      checks++; if (cmd_ready !== e_ready) begin failures++; $display("FAIL b2b_ready k=%0d got=%0b want=%0b", k, cmd_ready, e_ready); end
    end
    cmd_valid = 1'b0;
  endtask

`ifdef COUNTER_SEQUENCER_CAPTURE_EN
  task automatic test_capture();
    do_reset();
    send(OP_LOAD, 24'd100);
    pre_limit = 16'd1;
    auto_reload = 1'b0;
    send(OP_START, 24'd0);
    for (int k = 1; k <= 11; k++) step();
    capture = 1'b1;
    step();
    capture = 1'b0;
    checks++; if (cap_value !== 24'd5) begin failures++; $display("FAIL cap_value got=%0d want=5", cap_value); end
    checks++; if (ctr !== 24'd6) begin failures++; $display("FAIL cap_ctr got=%0d want=6", ctr); end
    step();
    step();
    checks++; if (cap_value !== 24'd5) begin failures++; $display("FAIL cap_hold got=%0d want=5", cap_value); end
  endtask
`endif

  task automatic test_random();
    int unsigned m_state, m_ctr, m_phase, m_term, m_limit, st0;
    bit m_auto, m_ready, m_tick, m_done, acc, halt;
    do_reset();
    m_state = ST_IDLE; m_ctr = 0; m_phase = 0; m_term = MAXC; m_limit = 1000;
    m_auto = 0; m_ready = 1; m_tick = 0; m_done = 0;
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      cmd_valid   = ($urandom_range(0, 3) == 0);
      cmd_op      = 2'($urandom_range(0, 3));
      if (cmd_op == OP_CLEAR && $urandom_range(0, 1) == 0) cmd_op = OP_START;
      cmd_data    = ($urandom_range(0, 9) == 0) ? 24'hFF_FFFF : 24'($urandom_range(0, 12));
      pre_limit   = 16'($urandom_range(0, 3));
      auto_reload = 1'($urandom_range(0, 1));

      if (rst) begin
        m_state = ST_IDLE; m_ctr = 0; m_phase = 0; m_term = MAXC; m_limit = 1000;
        m_auto = 0; m_ready = 1; m_tick = 0; m_done = 0;
      end else begin
        acc  = cmd_valid && m_ready;
        st0  = m_state;
        halt = acc && ((cmd_op == OP_STOP && st0 == ST_RUN) || cmd_op == OP_CLEAR);
        m_tick = 0;
        m_done = 0;
        if (st0 == ST_RUN && !halt) begin
          if (m_phase < m_limit) m_phase++;
          else begin
            m_phase = 0;
            m_tick = 1;
            if (m_ctr >= m_term) begin
              m_done = 1;
              if (m_auto) m_ctr = 0;
              else m_state = ST_DONE;
            end else m_ctr = (m_ctr + 1) % (MAXC + 1);
          end
        end
        if (acc) begin
          if (cmd_op == OP_START && (st0 == ST_IDLE || st0 == ST_DONE)) begin
            m_state = ST_RUN; m_ctr = 0; m_phase = 0; m_limit = pre_limit; m_auto = auto_reload;
          end else if (cmd_op == OP_START && st0 == ST_HOLD) m_state = ST_RUN;
          else if (cmd_op == OP_STOP && st0 == ST_RUN) m_state = ST_HOLD;
          else if (cmd_op == OP_LOAD) m_term = cmd_data;
          else if (cmd_op == OP_CLEAR) begin m_state = ST_IDLE; m_ctr = 0; m_phase = 0; end
        end
        m_ready = !acc;
      end

      step();
      checks++; if (ctr !== m_ctr) begin failures++; $display("FAIL rnd_ctr c=%0d got=%0d want=%0d", c, ctr, m_ctr); end
      checks++; if (tick !== m_tick) begin failures++; $display("FAIL rnd_tick c=%0d got=%0b want=%0b", c, tick, m_tick); end
      checks++; if (done !== m_done) begin failures++; $display("FAIL rnd_done c=%0d got=%0b want=%0b", c, done, m_done); end
      checks++; if (state !== m_state) begin failures++; $display("FAIL rnd_state c=%0d got=%0d want=%0d", c, state, m_state); end
      checks++; if (busy !== (m_state == ST_RUN)) begin failures++; $display("FAIL rnd_busy c=%0d got=%0b want=%0b", c, busy, (m_state == ST_RUN)); end
      checks++; if (cmd_ready !== m_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, cmd_ready, m_ready); end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_hold_resume();
    test_limit_zero();
    test_load_below();
    test_clear_on_terminal();
    test_back_to_back();
`ifdef COUNTER_SEQUENCER_CAPTURE_EN
    test_capture();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
